// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage RV32I pipeline.
// Tracks its own E/M/W register addresses, resolves RAW hazards by forwarding,
// inserts one bubble per load-use hazard, squashes D/E on a taken branch and
// keeps two saturating performance counters (stall cycles, flush cycles).
module hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              ResultSrcEb0,
    input  logic              PCSrcE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              cnt_clr,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [REG_AW-1:0] RdE;
    logic [REG_AW-1:0] RdM;
    logic [REG_AW-1:0] RdW;

    logic lwStall;

    // Forwarding select for one source register; Memory stage wins over Writeback,
    // and x0 never forwards because it is hard-wired to zero in the register file.
    function automatic logic [1:0] fwdSel(
        input logic [REG_AW-1:0] rsE,
        input logic [REG_AW-1:0] rdM,
        input logic [REG_AW-1:0] rdW,
        input logic              regWriteM,
        input logic              regWriteW
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rsE != REG_ZERO) begin
            if (regWriteM && (rsE == rdM)) begin
                sel = FWD_MEM;
            end else if (regWriteW && (rsE == rdW)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    // A load in Execute whose destination is read by the instruction in Decode.
    always_comb begin
        lwStall = 1'b0;
        if (ResultSrcEb0 && (RdE != REG_ZERO) && ((Rs1D == RdE) || (Rs2D == RdE))) begin
            lwStall = 1'b1;
        end
    end

    // Stall/flush/forward controls; all held inactive while reset is asserted.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!reset) begin
            // A taken branch squashes Decode anyway, so it overrides the stall.
            StallF    = lwStall && !PCSrcE;
            StallD    = lwStall && !PCSrcE;
            FlushD    = PCSrcE;
            FlushE    = lwStall || PCSrcE;
            ForwardAE = fwdSel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
            ForwardBE = fwdSel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
        end
    end

    // Shadow copies of the register addresses as instructions move down the pipe.
    always_ff @(posedge clock) begin
        if (reset) begin
            Rs1E <= '0;
            Rs2E <= '0;
            RdE  <= '0;
            RdM  <= '0;
            RdW  <= '0;
        end else begin
            RdW <= RdM;
            RdM <= RdE;
            if (FlushE) begin
                Rs1E <= '0;
                Rs2E <= '0;
                RdE  <= '0;
            end else begin
                Rs1E <= Rs1D;
                Rs2E <= Rs2D;
                RdE  <= RdD;
            end
        end
    end

    // Saturating count of load-use stall cycles; clear beats increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (StallD && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Saturating count of taken-branch flush cycles; clear beats increment.
    always_ff @(posedge clock) begin
        if (reset) begin
            flush_cnt <= '0;
        end else if (cnt_clr) begin
            flush_cnt <= '0;
        end else if (PCSrcE && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit. A second instance with 4-bit counters shares
// the stimulus so stall-counter saturation is reachable in a short run.
module tb_hazard_unit;

    logic        clock;
    logic        reset;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        ResultSrcEb0, PCSrcE, RegWriteM, RegWriteW, cnt_clr;
    logic        StallF, StallD, FlushD, FlushE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [15:0] stall_cnt, flush_cnt;
    logic        sStallF, sStallD, sFlushD, sFlushE;
    logic [1:0]  sForwardAE, sForwardBE;
    logic [3:0]  sStallCnt, sFlushCnt;

    int total = 0;
    int bad   = 0;

    hazard_unit dut (
        .clock(clock), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ResultSrcEb0(ResultSrcEb0), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .cnt_clr(cnt_clr), .StallF(StallF), .StallD(StallD),
        .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit #(.REG_AW(5), .CNT_W(4)) dutSat (
        .clock(clock), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ResultSrcEb0(ResultSrcEb0), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .cnt_clr(cnt_clr), .StallF(sStallF), .StallD(sStallD),
        .FlushD(sFlushD), .FlushE(sFlushE), .ForwardAE(sForwardAE), .ForwardBE(sForwardBE),
        .stall_cnt(sStallCnt), .flush_cnt(sFlushCnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; RdD = 0;
        ResultSrcEb0 = 0; PCSrcE = 0; RegWriteM = 0; RegWriteW = 0; cnt_clr = 0;
    endtask

    initial begin
        // Reset with hazard-looking inputs: controls must stay inactive.
        idle();
        reset = 1; PCSrcE = 1; ResultSrcEb0 = 1; RegWriteM = 1;
        settle();
        chk("rst_FlushD", 16'(FlushD), 16'd0);
        chk("rst_FlushE", 16'(FlushE), 16'd0);
        chk("rst_StallF", 16'(StallF), 16'd0);
        chk("rst_FwdA",   16'(ForwardAE), 16'd0);
        tick(); tick();
        idle(); reset = 0;
        settle();
        chk("rst_stallCnt", stall_cnt, 16'd0);
        chk("rst_flushCnt", flush_cnt, 16'd0);

        // Back-to-back dependency: distance 1 forwards from M, distance 2 from W.
        RdD = 5; tick();
        RdD = 0; Rs1D = 5; tick();
        settle();
        chk("t1_noRegWriteM", 16'(ForwardAE), 16'd0);
        RegWriteM = 1; settle();
        chk("t1_fwdM_A", 16'(ForwardAE), 16'd2);
        chk("t1_idle_B", 16'(ForwardBE), 16'd0);
        Rs1D = 0; Rs2D = 5; tick();
        RegWriteM = 0; RegWriteW = 1; settle();
        chk("t1_fwdW_B", 16'(ForwardBE), 16'd1);
        chk("t1_idle_A", 16'(ForwardAE), 16'd0);
        idle(); tick();

        // Priority: RdM == RdW == 3, Rs1E == 3.
        RdD = 3; tick();
        RdD = 3; tick();
        RdD = 0; Rs1D = 3; tick();
        RegWriteM = 1; RegWriteW = 1; settle();
        chk("t4_prioM", 16'(ForwardAE), 16'd2);
        RegWriteM = 0; settle();
        chk("t4_wOnly", 16'(ForwardAE), 16'd1);
        idle(); tick(); tick(); tick();
        RegWriteM = 1; RegWriteW = 1; settle();
        chk("t4_x0_A", 16'(ForwardAE), 16'd0);
        chk("t4_x0_B", 16'(ForwardBE), 16'd0);
        idle();

        // Load-use: load x7 in E, consumer reads x7 on Rs2.
        RdD = 7; tick();
        RdD = 8; Rs2D = 7; ResultSrcEb0 = 1; settle();
        chk("t2_StallF", 16'(StallF), 16'd1);
        chk("t2_StallD", 16'(StallD), 16'd1);
        chk("t2_FlushE", 16'(FlushE), 16'd1);
        chk("t2_FlushD", 16'(FlushD), 16'd0);
        chk("t2_cntBefore", stall_cnt, 16'd0);
        chk("t2_sat_StallF", 16'(sStallF), 16'd1);
        chk("t2_sat_StallD", 16'(sStallD), 16'd1);
        chk("t2_sat_FlushE", 16'(sFlushE), 16'd1);
        chk("t2_sat_FlushD", 16'(sFlushD), 16'd0);
        tick();
        ResultSrcEb0 = 0; RegWriteM = 1; settle();
        chk("t2_bubbleStall", 16'(StallD), 16'd0);
        chk("t2_bubbleFwdB", 16'(ForwardBE), 16'd0);
        chk("t2_cntAfter", stall_cnt, 16'd1);
        chk("t2_sat_bubbleA", 16'(sForwardAE), 16'd0);
        tick();
        RegWriteM = 0; RegWriteW = 1; settle();
        chk("t2_fwdW_B", 16'(ForwardBE), 16'd1);
        chk("t2_sat_fwdW_B", 16'(sForwardBE), 16'd1);
        chk("t2_cntHold", stall_cnt, 16'd1);
        idle(); tick(); tick(); tick();

        // Load to x0 never stalls.
        ResultSrcEb0 = 1; settle();
        chk("t4_x0Load_Stall", 16'(StallD), 16'd0);
        chk("t4_x0Load_FlushE", 16'(FlushE), 16'd0);
        idle();

        // Taken branch.
        PCSrcE = 1; settle();
        chk("t3_FlushD", 16'(FlushD), 16'd1);
        chk("t3_FlushE", 16'(FlushE), 16'd1);
        chk("t3_StallF", 16'(StallF), 16'd0);
        chk("t3_flushBefore", flush_cnt, 16'd0);
        tick();
        PCSrcE = 0; settle();
        chk("t3_flushAfter", flush_cnt, 16'd1);
        chk("t3_FlushD_off", 16'(FlushD), 16'd0);
        // Branch coinciding with a load-use condition.
        RdD = 6; tick();
        RdD = 0; Rs1D = 6; ResultSrcEb0 = 1; PCSrcE = 1; settle();
        chk("t3b_StallD", 16'(StallD), 16'd0);
        chk("t3b_StallF", 16'(StallF), 16'd0);
        chk("t3b_FlushE", 16'(FlushE), 16'd1);
        chk("t3b_FlushD", 16'(FlushD), 16'd1);
        tick();
        idle(); settle();
        chk("t3b_stallCnt", stall_cnt, 16'd1);
        chk("t3b_flushCnt", flush_cnt, 16'd2);

        // Counter clear, and clear together with an increment.
        cnt_clr = 1; tick();
        cnt_clr = 0; settle();
        chk("t5_clrStall", stall_cnt, 16'd0);
        chk("t5_clrFlush", flush_cnt, 16'd0);
        PCSrcE = 1; cnt_clr = 1; tick();
        idle(); settle();
        chk("t5_clrBeatsInc", flush_cnt, 16'd0);

        // Flush counter saturation.
        PCSrcE = 1;
        repeat (65540) tick();
        idle(); settle();
        chk("t5_flushSat", flush_cnt, 16'hFFFF);
        chk("t5_sat_flushSat", 16'(sFlushCnt), 16'hF);

        // Stall counter saturation on the narrow instance (20 stalls).
        for (int i = 0; i < 20; i++) begin
            RdD = 7; Rs1D = 0; ResultSrcEb0 = 0; tick();
            RdD = 0; Rs1D = 7; ResultSrcEb0 = 1; tick();
        end
        idle(); settle();
        chk("t5_stall20", stall_cnt, 16'd20);
        chk("t5_sat_stallSat", 16'(sStallCnt), 16'hF);
        chk("t5_sat_flushHold", 16'(sFlushCnt), 16'hF);
        // Clear during a stall cycle.
        RdD = 7; tick();
        RdD = 0; Rs1D = 7; ResultSrcEb0 = 1; cnt_clr = 1; settle();
        chk("t5_clrStallD", 16'(StallD), 16'd1);
        tick();
        idle(); settle();
        chk("t5_clrStallInc", stall_cnt, 16'd0);
        chk("t5_clrFlushSat", flush_cnt, 16'd0);
        chk("t5_sat_clrStall", 16'(sStallCnt), 16'd0);

        // Reset mid-stream during a load-use hazard with a live forward.
        PCSrcE = 1; tick();
        PCSrcE = 0; RdD = 9; tick();
        RdD = 7; Rs1D = 9; tick();
        RdD = 0; Rs1D = 7; ResultSrcEb0 = 1; RegWriteM = 1; settle();
        chk("t6_pre_FwdA", 16'(ForwardAE), 16'd2);
        chk("t6_pre_StallD", 16'(StallD), 16'd1);
        chk("t6_pre_flushCnt", flush_cnt, 16'd1);
        reset = 1; settle();
        chk("t6_rst_FwdA", 16'(ForwardAE), 16'd0);
        chk("t6_rst_StallD", 16'(StallD), 16'd0);
        chk("t6_rst_StallF", 16'(StallF), 16'd0);
        chk("t6_rst_FlushE", 16'(FlushE), 16'd0);
        tick();
        reset = 0; Rs2D = 9; RegWriteW = 1; settle();
        chk("t6_post_StallD", 16'(StallD), 16'd0);
        chk("t6_post_FwdA", 16'(ForwardAE), 16'd0);
        chk("t6_post_flushCnt", flush_cnt, 16'd0);
        chk("t6_post_stallCnt", stall_cnt, 16'd0);
        tick();
        ResultSrcEb0 = 0; Rs1D = 0; Rs2D = 0; settle();
        chk("t6_post2_FwdA", 16'(ForwardAE), 16'd0);
        chk("t6_post2_FwdB", 16'(ForwardBE), 16'd0);
        idle(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
